v_v2k_block_acc: RTL and testbench

//  Downstream consumer of the registered v_v2k sample stream (WIDTH+1-bit words).

---
 rtl/v_v2k_pkg.sv | 27 ++
 rtl/v_v2k_block_acc.sv | 135 +++++++++++++
 tb/tb_v_v2k_block_acc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/v_v2k_pkg.sv
// Shared definitions for the v_v2k sample path and its downstream consumers.
//   - v2k_state_e : block accumulator state (ACC collecting, HOLD output pending)
//   - clog2()     : ceiling log2 for deriving widths from parameters
//   - V2K_WIDTH   : default sample MSB index shared with the v_v2k stage
package v_v2k_pkg;

    localparam int V2K_WIDTH = 16;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } v2k_state_e;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/v_v2k_block_acc.sv
// v_v2k_block_acc
// Sums consecutive blocks of COUNT unsigned (WIDTH+1)-bit samples and emits one
// sum per block over a valid/ready handshake. A flush closes a partial block.
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   in_valid  in   in_data valid
//   in_ready  out  sample/flush accepted this cycle (= !out_valid | out_ready)
//   in_data   in   [WIDTH:0] unsigned sample
//   flush     in   close the current partial block (qualified by in_ready)
//   out_valid out  out_sum/out_cnt valid
//   out_ready in   downstream accepts the output
//   out_sum   out  [SUM_W-1:0] block sum, zero-extended
//   out_cnt   out  [CNT_W-1:0] number of samples in out_sum (1..COUNT)
module v_v2k_block_acc
    import v_v2k_pkg::*;
#(
    parameter int WIDTH = V2K_WIDTH,
    parameter int COUNT = 8,
    localparam int SUM_W = WIDTH + 1 + clog2(COUNT),
    localparam int CNT_W = clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    v2k_state_e       state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q,   out_sum_d;
    logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
    logic [SUM_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             flush_take_s;
    logic             close_s;
    logic             retire_s;
    logic [SUM_W-1:0] in_ext_s;
    logic [SUM_W-1:0] sum_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Handshake qualification and the running sum/count including this cycle's sample.
    always_comb begin
        in_ready_s   = !out_valid_q || out_ready;
        accept_s     = in_valid && in_ready_s;
        flush_take_s = flush && in_ready_s;
        retire_s     = out_valid_q && out_ready;
        // Extend before the add so the sum can never wrap.
        in_ext_s     = {{(SUM_W - WIDTH - 1){1'b0}}, in_data};
        if (accept_s) begin
            sum_next_s = acc_q + in_ext_s;
        end else begin
            sum_next_s = acc_q;
        end
        cnt_next_s = cnt_q + {{(CNT_W - 1){1'b0}}, accept_s};
        // A flush on an empty block (no held samples, no sample now) is ignored.
        close_s = (accept_s && (cnt_q == CNT_LAST)) ||
                  (flush_take_s && (cnt_next_s != {CNT_W{1'b0}}));
    end

    // Next-state for the accumulator, the counter and the output register.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (close_s) begin
            // Closing also covers retire-and-reload in the same cycle.
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = sum_next_s;
            out_cnt_d   = cnt_next_s;
            acc_d       = {SUM_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                acc_d = sum_next_s;
                cnt_d = cnt_next_s;
            end else begin
                acc_d = acc_q;
                cnt_d = cnt_q;
            end
            if (retire_s) begin
                state_d     = ST_ACC;
                out_valid_d = 1'b0;
            end else begin
                state_d     = state_q;
                out_valid_d = out_valid_q;
            end
        end
        case (state_d)
            ST_ACC:  out_valid_d = 1'b0;
            ST_HOLD: out_valid_d = 1'b1;
            default: out_valid_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
            out_sum_q   <= {SUM_W{1'b0}};
            out_cnt_q   <= {CNT_W{1'b0}};
            acc_q       <= {SUM_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_v_v2k_block_acc.sv
// Directed bench for v_v2k_block_acc with WIDTH=16, COUNT=4 (SUM_W=19, CNT_W=3).
// Each table row drives one cycle of inputs and states what the outputs must be
// just before the following clock edge (registered outputs reflect earlier cycles).
module tb_v_v2k_block_acc;

    localparam int WIDTH = 16;
    localparam int COUNT = 4;
    localparam int SUM_W = 19;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;

    int checks;
    int errors;

    typedef struct {
        logic             rs;
        logic             iv;
        logic [WIDTH:0]   d;
        logic             fl;
        logic             ordy;
        logic             e_rdy;
        logic             e_ov;
        logic [SUM_W-1:0] e_sum;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    v_v2k_block_acc #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rs, input logic iv, input logic [WIDTH:0] d,
                       input logic fl, input logic ordy, input logic e_rdy,
                       input logic e_ov, input logic [SUM_W-1:0] e_sum,
                       input logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.rs = rs; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sum = e_sum; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Drive one cycle, check pre-edge outputs, then advance past the edge.
    task automatic step(input string tag, input logic iv, input logic [WIDTH:0] d,
                        input logic fl, input logic ordy, input logic e_rdy,
                        input logic e_ov, input logic chk_data,
                        input logic [SUM_W-1:0] e_sum, input logic [CNT_W-1:0] e_cnt);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(e_rdy));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(e_ov));
        if (chk_data) begin
            check({tag, "_out_sum"}, 32'(out_sum), 32'(e_sum));
            check({tag, "_out_cnt"}, 32'(out_cnt), 32'(e_cnt));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 17'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        //   rs    iv    d          fl    ordy  rdy   ov    sum         cnt
        // back-to-back 1,2,3,4 -> 10 for exactly one cycle
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd3,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd4,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'd10,     3'd4);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        // maximum samples, no wrap
        add(1'b0, 1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'h1FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'h7FFFC,  3'd4);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        // 5,6 then flush -> 11/2
        add(1'b0, 1'b1, 17'd5,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd6,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b1, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'd11,     3'd2);
        // flush on an empty block is ignored
        add(1'b0, 1'b0, 17'd0,     1'b1, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        // flush together with the 4th sample -> single full block
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b1, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'd4,      3'd4);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        // 8 samples of 2 in 8 cycles, in_ready never drops
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b1, 19'd8,      3'd4);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd2,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'd8,      3'd4);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        // reset mid-block discards the partial sum of 27
        add(1'b0, 1'b1, 17'd9,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd9,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd9,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b1, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b1, 17'd1,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b1, 19'd4,      3'd4);
        add(1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 1'b1, 1'b0, 19'd0,      3'd0);

        // Reset state
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_cnt", 32'(out_cnt), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rs;
            step($sformatf("vec%0d", i), vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy,
                 vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_ov, vecs[i].e_sum, vecs[i].e_cnt);
        end
        rst = 1'b0;

        // Back-pressure: block of 3s closes with out_ready low
        for (int i = 0; i < 4; i++) begin
            step("bp_fill", 1'b1, 17'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        end
        // Held output: in_valid and flush must be ignored for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b1, 17'd99, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 19'd12, 3'd4);
        end
        // Retire and start a new block with 7 in the same cycle
        step("bp_retire", 1'b1, 17'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd12, 3'd4);
        step("bp_b2", 1'b1, 17'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        step("bp_b3", 1'b1, 17'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        step("bp_b4", 1'b1, 17'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);
        // 7+1+1+1 proves the sample 7 opened a block of count 1; flush with a new
        // sample while retiring keeps out_valid high with a one-sample block
        step("rf_close", 1'b1, 17'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd10, 3'd4);
        step("rf_new", 1'b0, 17'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd5, 3'd1);
        step("rf_idle", 1'b0, 17'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
